// File: rtl/systolic_io.sv
// systolic_io: replays a weight matrix into a weight-stationary array, skews input vectors in and
// de-skews column results out. Optional output FIFO with y_ready back-pressure: SYSTOLIC_IO_OUT_FIFO_EN.
module systolic_io #(
  parameter int DATA_SIZE = 16,
  parameter int SIZE      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SIZE*DATA_SIZE-1:0] w_in,
  input  logic                      w_in_valid,
  output logic                      w_in_ready,
  input  logic [SIZE*DATA_SIZE-1:0] x_in,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic [SIZE*DATA_SIZE-1:0] y_out,
  output logic                      y_valid,
`ifdef SYSTOLIC_IO_OUT_FIFO_EN
  input  logic                      y_ready,
`endif
  output logic [SIZE*DATA_SIZE-1:0] arr_data_stream,
  output logic [SIZE*DATA_SIZE-1:0] arr_w_stream,
  output logic                      arr_set_w,
  input  logic [SIZE*DATA_SIZE-1:0] arr_y_stream
);

  localparam int L  = 2*SIZE + 1;
  localparam int CW = $clog2(L + 1);
  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, WCOLLECT, WPUSH, WGAP, RUN, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [SIZE*DATA_SIZE-1:0] wbuf [SIZE];
  logic [BW-1:0]             bcnt, pcnt;
  logic                      w_acc, x_acc, res_out;
  logic                      credit_ok, drain_done;
  logic [CW-1:0]             inflight;
  logic [L-1:0]              vshift;
  logic [SIZE*DATA_SIZE-1:0] dsk_out;

  // Handshakes: a weight beat or vector transfers on the rising edge where valid && ready are both 1.
  assign w_acc = w_in_valid && w_in_ready;
  assign x_acc = x_valid && x_ready;

  always_comb begin
    state_nxt    = state;
    w_in_ready   = 1'b0;
    x_ready      = 1'b0;
    arr_set_w    = 1'b0;
    arr_w_stream = '0;
    unique case (state)
      IDLE, WCOLLECT: begin
        w_in_ready = rst_n;
        if (w_in_valid && rst_n) state_nxt = (bcnt == LAST_BEAT) ? WPUSH : WCOLLECT;
      end
      WPUSH: begin
        arr_set_w    = 1'b1;
        arr_w_stream = wbuf[pcnt];
        if (pcnt == LAST_BEAT) state_nxt = WGAP;
      end
      WGAP: state_nxt = RUN;
      RUN: begin
        // A pending weight request wins over new vectors so the array can drain.
        x_ready = !w_in_valid && credit_ok;
        if (w_in_valid) state_nxt = DRAIN;
      end
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
      pcnt  <= '0;
      for (int i = 0; i < SIZE; i++) wbuf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (w_acc) begin
        wbuf[bcnt] <= w_in;
        bcnt       <= (bcnt == LAST_BEAT) ? '0 : bcnt + 1'b1;
      end
      if (state == WPUSH) pcnt <= (pcnt == LAST_BEAT) ? '0 : pcnt + 1'b1;
    end
  end

  // Row r gets r+1 stages so it reaches the array r cycles after row 0.
  for (genvar r = 0; r < SIZE; r++) begin : g_skew
    logic [DATA_SIZE-1:0] pipe [r+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= r; j++) pipe[j] <= '0;
      end else begin
        pipe[0] <= x_acc ? x_in[(SIZE-r)*DATA_SIZE-1 -: DATA_SIZE] : '0;
        for (int j = 1; j <= r; j++) pipe[j] <= pipe[j-1];
      end
    end
    assign arr_data_stream[(SIZE-r)*DATA_SIZE-1 -: DATA_SIZE] = pipe[r];
  end

  // Column c leaves the array c cycles late; SIZE-c stages (last one is the output register) realign it.
  for (genvar c = 0; c < SIZE; c++) begin : g_deskew
    logic [DATA_SIZE-1:0] pipe [SIZE-c];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < SIZE - c; j++) pipe[j] <= '0;
      end else begin
        pipe[0] <= arr_y_stream[(SIZE-c)*DATA_SIZE-1 -: DATA_SIZE];
        for (int j = 1; j < SIZE - c; j++) pipe[j] <= pipe[j-1];
      end
    end
    assign dsk_out[(SIZE-c)*DATA_SIZE-1 -: DATA_SIZE] = pipe[SIZE-1-c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vshift   <= '0;
      inflight <= '0;
    end else begin
      vshift <= {vshift[L-2:0], x_acc};
      unique case ({x_acc, res_out})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign res_out = vshift[L-1];

`ifdef SYSTOLIC_IO_OUT_FIFO_EN
  localparam int PW = $clog2(L);

  logic [SIZE*DATA_SIZE-1:0] fifo [L];
  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [CW-1:0]             fcount;
  logic                      pop;

  assign pop        = y_valid && y_ready;
  assign y_valid    = (fcount != '0);
  assign y_out      = fifo[rd_ptr];
  // Credits cover both the pipeline and the FIFO, so a push never finds the FIFO full.
  assign credit_ok  = ({1'b0, inflight} + {1'b0, fcount}) < (CW+1)'(L);
  assign drain_done = (inflight == '0) && (fcount == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fcount <= '0;
      for (int i = 0; i < L; i++) fifo[i] <= '0;
    end else begin
      if (res_out) begin
        fifo[wr_ptr] <= dsk_out;
        wr_ptr       <= (wr_ptr == PW'(L-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(L-1)) ? '0 : rd_ptr + 1'b1;
      unique case ({res_out, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end
`else
  assign y_valid    = res_out;
  assign y_out      = dsk_out;
  assign credit_ok  = 1'b1;
  assign drain_done = (inflight == '0);
`endif

endmodule

// File: tb/tb_systolic_io.sv
// tb_systolic_io: directed test of systolic_io around a behavioural weight-stationary array model,
// with an expected-result queue checked by an independent output monitor.
`timescale 1ns/1ps
module tb_systolic_io;

  localparam int D = 16;
  localparam int S = 3;
  localparam int L = 2*S + 1;
  localparam int W = S*D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] w_in = '0;
  logic         w_in_valid = 1'b0;
  logic         w_in_ready;
  logic [W-1:0] x_in = '0;
  logic         x_valid = 1'b0;
  logic         x_ready;
  logic [W-1:0] y_out;
  logic         y_valid;
`ifdef SYSTOLIC_IO_OUT_FIFO_EN
  logic         y_ready = 1'b1;
`endif
  logic [W-1:0] arr_data_stream;
  logic [W-1:0] arr_w_stream;
  logic         arr_set_w;
  logic [W-1:0] arr_y_stream;

  systolic_io #(.DATA_SIZE(D), .SIZE(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .w_in(w_in),
    .w_in_valid(w_in_valid),
    .w_in_ready(w_in_ready),
    .x_in(x_in),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .y_out(y_out),
    .y_valid(y_valid),
`ifdef SYSTOLIC_IO_OUT_FIFO_EN
    .y_ready(y_ready),
`endif
    .arr_data_stream(arr_data_stream),
    .arr_w_stream(arr_w_stream),
    .arr_set_w(arr_set_w),
    .arr_y_stream(arr_y_stream)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] v3(input int a, input int b, input int c);
    logic [D-1:0] ea, eb, ec;
    ea = a[D-1:0];
    eb = b[D-1:0];
    ec = c[D-1:0];
    return {ea, eb, ec};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural weight-stationary array ----------------
  // PE(k,c) holds W[c][k]; x_k moves right one PE per cycle, partial sums move down one row per cycle.
  logic [D-1:0] wt   [S][S];
  logic [D-1:0] dreg [S][S];
  logic [D-1:0] psum [S][S];
  int           wcnt;

  initial begin
    wcnt = 0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        wt[i][j]   = '0;
        dreg[i][j] = '0;
        psum[i][j] = '0;
      end
  end

  function automatic logic [D-1:0] pe_x(input int k, input int c);
    if (c == 0) return arr_data_stream[(S-k)*D-1 -: D];
    return dreg[k][c-1];
  endfunction

  always @(posedge clk) begin
    if (arr_set_w) begin
      for (int c = 0; c < S; c++) wt[c][wcnt] <= arr_w_stream[(S-c)*D-1 -: D];
      wcnt <= (wcnt + 1) % S;
    end else begin
      wcnt <= 0;
    end
    for (int k = 0; k < S; k++)
      for (int c = 0; c < S; c++) begin
        dreg[k][c] <= pe_x(k, c);
        psum[k][c] <= ((k == 0) ? D'(0) : psum[(k == 0) ? 0 : k-1][c]) + D'(wt[c][k] * pe_x(k, c));
      end
  end

  always_comb begin
    arr_y_stream = '0;
    for (int c = 0; c < S; c++) arr_y_stream[(S-c)*D-1 -: D] = psum[S-1][c];
  end

  // ---------------- monitor ----------------
  logic take;
`ifdef SYSTOLIC_IO_OUT_FIFO_EN
  assign take = y_valid && y_ready;
`else
  assign take = y_valid;
`endif

  always @(negedge clk) begin
    logic [W-1:0] e;
    int           a;
    if (rst_n && take) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y: y_out=%0h with no result pending (cycle %0d)", y_out, cyc);
      end else begin
        e = exp_q.pop_front();
        a = lat_q.pop_front();
        chk("y_out", y_out, e);
`ifndef SYSTOLIC_IO_OUT_FIFO_EN
        chk("y_latency", W'(cyc - a), W'(L));
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_vec(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    x_in    = x;
    x_valid = 1'b1;
    @(negedge clk);
    while (!x_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (x_ready) begin
      exp_q.push_back(y);
      lat_q.push_back(cyc);
    end else begin
      checks++;
      errors++;
      $display("FAIL x_accept_timeout: x_ready got 0 expected 1 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_in    = '0;
  endtask

  task automatic load_w(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2);
    logic [W-1:0] bt [S];
    int           n;
    bt[0] = b0;
    bt[1] = b1;
    bt[2] = b2;
    for (int k = 0; k < S; k++) begin
      w_in       = bt[k];
      w_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!w_in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!w_in_ready) begin
        checks++;
        errors++;
        $display("FAIL w_accept_timeout: w_in_ready got 0 expected 1 for beat %0d", k);
      end
      @(posedge clk);
      #1;
    end
    w_in_valid = 1'b0;
    w_in       = '0;
    n = 0;
    @(negedge clk);
    while (!arr_set_w && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("set_w_start", W'(arr_set_w), W'(1));
    chk("results_before_reload", W'(exp_q.size()), W'(0));
    for (int k = 0; k < S; k++) begin
      chk("set_w_high", W'(arr_set_w), W'(1));
      chk("push_beat", arr_w_stream, bt[k]);
      @(negedge clk);
    end
    chk("gap_set_w", W'(arr_set_w), W'(0));
    chk("gap_w_stream", arr_w_stream, '0);
    chk("gap_x_ready", W'(x_ready), W'(0));
    @(negedge clk);
    chk("run_x_ready", W'(x_ready), W'(1));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_w_in_ready", W'(w_in_ready), W'(0));
    chk("rst_x_ready", W'(x_ready), W'(0));
    chk("rst_y_valid", W'(y_valid), W'(0));
    chk("rst_y_out", y_out, '0);
    chk("rst_set_w", W'(arr_set_w), W'(0));
    chk("rst_data_stream", arr_data_stream, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_w_in_ready", W'(w_in_ready), W'(1));
    chk("idle_x_ready", W'(x_ready), W'(0));
    @(posedge clk);
    #1;

    // W = [[1,2,3],[4,5,6],[7,8,9]]; beat k carries column k
    load_w(v3(1, 4, 7), v3(2, 5, 8), v3(3, 6, 9));

    send_vec(v3(1, 1, 1), v3(6, 15, 24));
    repeat (10) @(posedge clk);
    #1;

    send_vec(v3(1, 0, 0), v3(1, 4, 7));
    send_vec(v3(0, 1, 0), v3(2, 5, 8));
    send_vec(v3(0, 0, 1), v3(3, 6, 9));

    // Weight request with vectors in flight, offered together with a new vector
    w_in       = v3(1, 0, 0);
    w_in_valid = 1'b1;
    x_in       = v3(9, 9, 9);
    x_valid    = 1'b1;
    @(negedge clk);
    chk("x_ready_blocked_by_w", W'(x_ready), W'(0));
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_in    = '0;
    load_w(v3(1, 0, 0), v3(0, 1, 0), v3(0, 0, 1));

    send_vec(v3(5, 6, 7), v3(5, 6, 7));
    send_vec(v3(2, 3, 4), v3(2, 3, 4));

    // Reset with two results in flight: they are lost
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    chk("midrst_y_valid", W'(y_valid), W'(0));
    chk("midrst_x_ready", W'(x_ready), W'(0));
    chk("midrst_y_out", y_out, '0);
    chk("midrst_data_stream", arr_data_stream, '0);
    chk("midrst_set_w", W'(arr_set_w), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    x_in    = v3(3, 3, 3);
    x_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_x_ready", W'(x_ready), W'(0));
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_in    = '0;

    load_w(v3(1, 4, 7), v3(2, 5, 8), v3(3, 6, 9));
    send_vec(v3(1, 2, 3), v3(14, 32, 50));
    send_vec(v3(2, 0, 1), v3(5, 14, 23));

`ifdef SYSTOLIC_IO_OUT_FIFO_EN
    repeat (12) @(posedge clk);
    #1;
    y_ready = 1'b0;
    for (int k = 1; k <= L; k++) send_vec(v3(k, 0, 0), v3(k, 4*k, 7*k));
    x_in    = v3(1, 1, 1);
    x_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("fifo_credit_x_ready", W'(x_ready), W'(0));
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_in    = '0;
    y_ready = 1'b1;
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    chk("all_results_seen", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
